instr_fetch: RTL and testbench

//  Instruction fetch stage around the program counter. Reads the current PC (prog count_o),

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_fifo.sv | 68 ++++++
 rtl/instr_fetch.sv | 131 +++++++++++++
 tb/tb_instr_fetch.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//  - fetch_state_e : fetch FSM states
//  - fetch_entry_t : one buffered instruction (its PC, the fetched word, bus error flag)
//  - word_align    : clears the two low address bits
package fetch_pkg;

  localparam int              ILEN   = 32;
  localparam logic [ILEN-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    FLUSH
  } fetch_state_e;

  typedef struct packed {
    logic [ILEN-1:0] pc;
    logic [ILEN-1:0] instr;
    logic            err;
  } fetch_entry_t;

  function automatic logic [ILEN-1:0] word_align(input logic [ILEN-1:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch_entry_t used as the fetch instruction buffer.
// Ports:
//  clk, rst   clock, asynchronous active-high reset
//  push       write push_data (ignored when full unless a pop frees the slot)
//  push_data  entry to write
//  pop        drop the head entry (ignored when empty)
//  flush      empty the FIFO; dominates push and pop
//  head       current head entry (contents undefined while empty)
//  count      number of stored entries
//  full/empty occupancy flags
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  input  logic                       flush,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  // A pop in the same cycle frees the slot, so push-while-full is legal then.
  assign do_push = push && (!full || do_pop) && !flush;
  assign head    = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: the storage array is deliberately not reset; validity is tracked by
  // count alone, and leaving the RAM out of reset keeps it a plain memory.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage.
// Reads the current PC, requests words from instruction memory over a
// req/gnt/rvalid handshake (one transaction in flight at most), advances or
// redirects the PC, and buffers returned words with their PC for decode.
// Ports:
//  clk_i, rst_i                    clock, asynchronous active-high reset
//  pc_i / pc_ld_o / pc_data_o      program counter read and load port
//  redirect_i / redirect_pc_i      branch/jump/trap redirect
//  imem_req_o / imem_addr_o        memory request and word-aligned address
//  imem_gnt_i                      request accepted
//  imem_rvalid_i / imem_rdata_i    response valid and data
//  imem_err_i                      bus error, qualified by imem_rvalid_i
//  instr_valid_o / instr_ready_i   decode handshake
//  instr_o / instr_pc_o / instr_err_o  head instruction, its PC, its error flag
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [31:0]     pc_i,
  output logic            pc_ld_o,
  output logic [31:0]     pc_data_o,
  input  logic            redirect_i,
  input  logic [31:0]     redirect_pc_i,
  output logic            imem_req_o,
  output logic [31:0]     imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  input  logic            imem_err_i,
  output logic            instr_valid_o,
  input  logic            instr_ready_i,
  output logic [31:0]     instr_o,
  output logic [31:0]     instr_pc_o,
  output logic            instr_err_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  state;
  fetch_state_e  state_nxt;
  logic [31:0]   inflight_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] count_after;
  logic          full;
  logic          empty;
  logic          grant;
  logic          push;
  logic          pop;
  fetch_entry_t  head;
  fetch_entry_t  push_data;

  assign imem_req_o  = (state == REQ);
  assign imem_addr_o = imem_req_o ? word_align(pc_i) : '0;
  assign grant       = imem_req_o && imem_gnt_i;

  // A redirect drops a same-cycle response and suppresses the pop; the FIFO
  // itself is flushed by the redirect.
  assign push        = (state == WAIT) && imem_rvalid_i && !redirect_i;
  assign pop         = instr_valid_o && instr_ready_i && !redirect_i;
  assign count_after = count + CW'(push) - CW'(pop);
  assign push_data   = '{pc: inflight_pc, instr: imem_rdata_i, err: imem_err_i};

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_i),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign instr_valid_o = !empty;
  assign instr_o       = empty ? '0 : head.instr;
  assign instr_pc_o    = empty ? '0 : head.pc;
  assign instr_err_o   = empty ? 1'b0 : head.err;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      inflight_pc <= '0;
    end else begin
      state <= state_nxt;
      if (grant) inflight_pc <= word_align(pc_i);
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    pc_ld_o   = 1'b0;
    pc_data_o = '0;

    if (redirect_i) begin
      pc_ld_o   = 1'b1;
      pc_data_o = word_align(redirect_pc_i);
    end else if (grant) begin
      pc_ld_o   = 1'b1;
      pc_data_o = pc_i + PC_INC;
    end

    unique case (state)
      // No push can happen in IDLE, so a free slot after this cycle means
      // "not full, or a pop is draining one". A redirect empties the FIFO.
      IDLE: if (redirect_i || !full || pop) state_nxt = REQ;
      // Without a grant the request is simply re-presented; after a redirect
      // it carries the new PC next cycle.
      REQ: if (grant) state_nxt = redirect_i ? FLUSH : WAIT;
      WAIT: begin
        if (imem_rvalid_i) begin
          state_nxt = (redirect_i || count_after < CW'(FIFO_DEPTH)) ? REQ : IDLE;
        end else if (redirect_i) begin
          state_nxt = FLUSH;
        end
      end
      // The discarded response retires the in-flight transaction even if a
      // further redirect arrives with it; the PC load already carries the
      // newest target.
      FLUSH: if (imem_rvalid_i) state_nxt = REQ;
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: the bench plays the program counter,
// a randomized instruction memory and a randomized decode stage. Accepted
// responses are queued as expected instructions; a monitor compares the
// FIFO head every cycle and pops on each decode handshake.
module tb_instr_fetch;
  import fetch_pkg::*;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = '0;
  logic        pc_ld;
  logic [31:0] pc_data;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        imem_err = 1'b0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_err;

  instr_fetch #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .pc_i          (pc),
    .pc_ld_o       (pc_ld),
    .pc_data_o     (pc_data),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_gnt_i    (imem_gnt),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .imem_err_i    (imem_err),
    .instr_valid_o (instr_valid),
    .instr_ready_i (instr_ready),
    .instr_o       (instr),
    .instr_pc_o    (instr_pc),
    .instr_err_o   (instr_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus knobs, set by the directed sequence.
  int          gnt_pct = 100, ready_pct = 100, redir_pct = 0, err_pct = 0, max_delay = 1;
  int          force_kind = 0;  // 1: redirect in WAIT w/o rvalid, 2: with gnt, 3: now
  logic [31:0] force_pc = '0;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = '0;

  // Reference model state.
  fetch_entry_t exp_q[$];
  fetch_entry_t pop_log[$];
  logic [31:0]  grant_log[$];
  int           pops = 0;
  int           occ_start = 0;
  logic         mem_busy = 1'b0;
  int           mem_cnt = 0;
  logic [31:0]  mem_addr = '0;
  int           mem_epoch = 0, cur_epoch = 0;
  logic [31:0]  exp_addr = '0, next_pc = '0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h5a5a_1234;
  endfunction

  // Memory, decode and PC-register stimulus plus the reference model.
  initial begin : stim
    logic         pend_push, pend_flush, grant, prev_hold;
    logic [31:0]  prev_addr;
    fetch_entry_t pend_entry;
    pend_push = 0; pend_flush = 0; prev_hold = 0; prev_addr = '0; pend_entry = '0;
    forever begin
      @(posedge clk); #1;
      if (pend_flush) exp_q.delete();
      if (pend_push)  exp_q.push_back(pend_entry);
      pend_flush = 0; pend_push = 0;
      pc = next_pc;
      occ_start = exp_q.size();

      imem_rvalid = 0; imem_err = 0; imem_rdata = '0;
      if (mem_busy) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_rvalid = 1;
          imem_rdata  = mem_word(mem_addr);
          imem_err    = (err_en && mem_addr == err_addr) || ($urandom_range(99) < err_pct);
        end
      end
      imem_gnt    = imem_req && ($urandom_range(99) < gnt_pct);
      instr_ready = ($urandom_range(99) < ready_pct);
      redirect    = 0;
      redirect_pc = $urandom;
      if (!rst) begin
        if (force_kind == 1 && mem_busy && !imem_rvalid ||
            force_kind == 2 && imem_gnt || force_kind == 3) begin
          redirect = 1; redirect_pc = force_pc; force_kind = 0;
        end else if ($urandom_range(99) < redir_pct) begin
          redirect = 1;
        end
      end

      @(negedge clk);
      grant = imem_req && imem_gnt;
      if (rst) begin
        check("pc_ld_in_reset", pc_ld, 0);
        if (imem_rvalid) mem_busy = 0;
        cur_epoch++;
        pend_flush = 1;
        exp_addr = pc;
        next_pc = pc;
        prev_hold = 0;
      end else begin
        if (prev_hold) begin
          check("req_held", imem_req, 1);
          check("req_addr_held", imem_addr, prev_addr);
        end
        if (imem_req) check("fetch_addr", imem_addr, exp_addr);
        if (grant) begin
          check("one_in_flight", mem_busy, 0);
          check("space_rule", occ_start < DEPTH, 1);
        end
        if (imem_rvalid) begin
          mem_busy = 0;
          if (!redirect && mem_epoch == cur_epoch) begin
            pend_push  = 1;
            pend_entry = '{pc: mem_addr, instr: imem_rdata, err: imem_err};
          end
        end
        if (grant) begin
          grant_log.push_back(imem_addr);
          mem_busy  = 1;
          mem_addr  = imem_addr;
          mem_cnt   = $urandom_range(max_delay, 1);
          mem_epoch = cur_epoch;
        end
        if (redirect) begin
          check("pc_ld_redirect", pc_ld, 1);
          check("pc_data_redirect", pc_data, redirect_pc & ~32'd3);
          exp_addr = redirect_pc & ~32'd3;
          cur_epoch++;
          pend_flush = 1;
        end else if (grant) begin
          check("pc_ld_gnt", pc_ld, 1);
          check("pc_data_gnt", pc_data, exp_addr + 32'd4);
          exp_addr = exp_addr + 32'd4;
        end else begin
          check("pc_ld_idle", pc_ld, 0);
        end
        next_pc   = pc_ld ? pc_data : pc;
        prev_hold = imem_req && !grant && !redirect;
        prev_addr = imem_addr;
      end
    end
  end

  // Monitor: compares the FIFO head with the oldest expected entry.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (rst) begin
        check("valid_in_reset", instr_valid, 0);
      end else begin
        check("instr_valid", instr_valid, exp_q.size() > 0);
        if (exp_q.size() > 0) begin
          check("instr_pc", instr_pc, exp_q[0].pc);
          check("instr", instr, exp_q[0].instr);
          check("instr_err", instr_err, exp_q[0].err);
          if (instr_valid && instr_ready && !redirect) begin
            void'(exp_q.pop_front());
            pop_log.push_back('{pc: instr_pc, instr: instr, err: instr_err});
            pops++;
          end
        end else begin
          check("instr_empty", instr, 0);
          check("instr_pc_empty", instr_pc, 0);
          check("instr_err_empty", instr_err, 0);
        end
      end
    end
  end

  task automatic wait_force(input string name);
    int n;
    n = 0;
    while (force_kind != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    check(name, force_kind == 0, 1);
  endtask

  task automatic wait_grant(input string name, input logic [31:0] exp);
    int n, base;
    n = 0;
    base = grant_log.size();
    while (grant_log.size() == base && n < 40) begin
      @(posedge clk);
      n++;
    end
    if (grant_log.size() > base) check(name, grant_log[base], exp);
    else check({name, "_timeout"}, 0, 1);
  endtask

  initial begin : main
    int p0, n;
    logic [31:0] restart_pc;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst_pc_ld", pc_ld, 0);
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_instr_pc", instr_pc, 0);
    check("rst_instr_err", instr_err, 0);
    @(posedge clk); #2 rst = 0;
    grant_log.delete();

    // 1: streaming from PC 0, one instruction every two cycles.
    repeat (10) @(posedge clk);
    p0 = pops;
    repeat (20) @(posedge clk);
    check("throughput", pops - p0, 10);
    check("first_addr0", grant_log[0], 32'h0);
    check("first_addr1", grant_log[1], 32'h4);
    check("first_addr2", grant_log[2], 32'h8);

    // 2: decode stalls; FIFO fills and requests stop.
    ready_pct = 0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("stall_valid", instr_valid, 1);
    check("stall_req", imem_req, 0);
    @(posedge clk);
    ready_pct = 100;
    wait_grant("resume_grant", exp_addr);

    // 3: redirect while waiting for a response.
    max_delay = 3;
    force_pc = 32'h100; force_kind = 1;
    wait_force("force_wait_redirect");
    @(negedge clk);
    check("flush_empty", instr_valid, 0);
    wait_grant("redirect_addr", 32'h100);

    // 4: redirect to an unaligned target on the grant cycle.
    force_pc = 32'h203; force_kind = 2;
    wait_force("force_gnt_redirect");
    wait_grant("redirect_gnt_addr", 32'h200);

    // 5: bus error at 0x10; fetch continues at 0x14.
    err_en = 1; err_addr = 32'h10;
    force_pc = 32'h10; force_kind = 3;
    wait_force("force_err_redirect");
    pop_log.delete();
    n = 0;
    while (pop_log.size() < 2 && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (pop_log.size() >= 2) begin
      check("err_pc", pop_log[0].pc, 32'h10);
      check("err_flag", pop_log[0].err, 1);
      check("after_err_pc", pop_log[1].pc, 32'h14);
      check("after_err_flag", pop_log[1].err, 0);
    end else begin
      check("err_pops_timeout", pop_log.size(), 2);
    end
    err_en = 0;

    // 6: reset in WAIT with an entry buffered.
    ready_pct = 0;
    n = 0;
    while (!(mem_busy && exp_q.size() > 0) && n < 40) begin
      @(posedge clk);
      n++;
    end
    check("reach_wait_with_entry", mem_busy && exp_q.size() > 0, 1);
    #2 rst = 1;
    #1;
    check("reset_now_valid", instr_valid, 0);
    check("reset_now_req", imem_req, 0);
    n = 0;
    while (mem_busy && n < 10) begin
      @(posedge clk);
      n++;
    end
    @(posedge clk);
    restart_pc = pc;
    #2 rst = 0;
    ready_pct = 100;
    wait_grant("restart_addr", restart_pc);

    // Randomized traffic.
    gnt_pct = 70; ready_pct = 60; redir_pct = 4; err_pct = 10; max_delay = 3;
    repeat (3000) @(posedge clk);
    redir_pct = 0; ready_pct = 100;
    repeat (20) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
